// File: rtl/boton_antirrebote.sv
// boton_antirrebote: 2-FF sync + stability counter debouncer with press pulses.
// Optional auto-repeat when BOTON_ANTIRREBOTE_AUTOREPETICION_EN is defined.
module boton_antirrebote #(
  parameter int NUM_BOTONES        = 4,
  parameter int CICLOS_ESTABLES    = 500000,
  parameter bit ACTIVO_ALTO        = 1'b1,
  parameter int RETARDO_REPETICION = 25000000,
  parameter int PERIODO_REPETICION = 5000000
) (
  input  logic                   reloj,
  input  logic                   reinicio,
  input  logic [NUM_BOTONES-1:0] entradaBotones,
  output logic [NUM_BOTONES-1:0] salidaNivel,
  output logic [NUM_BOTONES-1:0] salidaPulsos
);

  localparam int CW = $clog2(CICLOS_ESTABLES + 1);
  localparam logic [CW-1:0] LIMITE = CW'(CICLOS_ESTABLES - 1);

  logic [NUM_BOTONES-1:0] w_pol;
  logic [NUM_BOTONES-1:0] r_sinc1;
  logic [NUM_BOTONES-1:0] r_sinc2;
  logic [NUM_BOTONES-1:0] r_nivel;
  logic [NUM_BOTONES-1:0] w_nivel_sig;
  logic [NUM_BOTONES-1:0] w_sube;
  logic [NUM_BOTONES-1:0] w_rep_pulso;
  logic [NUM_BOTONES-1:0] w_pulsos_sig;
  logic [NUM_BOTONES-1:0] r_pulsos;
  logic [CW-1:0]          r_cuenta     [NUM_BOTONES];
  logic [CW-1:0]          w_cuenta_sig [NUM_BOTONES];

  // Polarity correction ahead of the synchronizer: 1 always means pressed.
  assign w_pol = ACTIVO_ALTO ? entradaBotones : ~entradaBotones;

  // Two-flop synchronizer; r_sinc2 is the only sample the logic ever sees.
  always_ff @(posedge reloj) begin
    if (reinicio) begin
      r_sinc1 <= '0;
      r_sinc2 <= '0;
    end else begin
      r_sinc1 <= w_pol;
      r_sinc2 <= r_sinc1;
    end
  end

  // Stability counter: a new level must persist CICLOS_ESTABLES edges.
  always_comb begin
    for (int i = 0; i < NUM_BOTONES; i++) begin
      w_nivel_sig[i]  = r_nivel[i];
      w_cuenta_sig[i] = '0;
      if (r_sinc2[i] == r_nivel[i]) begin
        w_cuenta_sig[i] = '0;
      end else if (r_cuenta[i] == LIMITE) begin
        w_nivel_sig[i]  = r_sinc2[i];
        w_cuenta_sig[i] = '0;
      end else begin
        w_cuenta_sig[i] = r_cuenta[i] + CW'(1);
      end
    end
  end

  // Press edge: level is about to go 0 -> 1 on this clock.
  assign w_sube = w_nivel_sig & ~r_nivel;

`ifdef BOTON_ANTIRREBOTE_AUTOREPETICION_EN

  localparam int RMAX =
    (RETARDO_REPETICION > PERIODO_REPETICION) ?
    RETARDO_REPETICION : PERIODO_REPETICION;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] LIM_RET = RW'(RETARDO_REPETICION - 1);
  localparam logic [RW-1:0] LIM_PER = RW'(PERIODO_REPETICION - 1);

  typedef enum logic {
    REP_RETARDO,
    REP_PERIODO
  } rep_e;

  rep_e          r_fase       [NUM_BOTONES];
  rep_e          w_fase_sig   [NUM_BOTONES];
  logic [RW-1:0] r_rep        [NUM_BOTONES];
  logic [RW-1:0] w_rep_sig    [NUM_BOTONES];

  // Repeat phase and counter registers; cleared on reset.
  always_ff @(posedge reloj) begin
    if (reinicio) begin
      for (int i = 0; i < NUM_BOTONES; i++) begin
        r_fase[i] <= REP_RETARDO;
        r_rep[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BOTONES; i++) begin
        r_fase[i] <= w_fase_sig[i];
        r_rep[i]  <= w_rep_sig[i];
      end
    end
  end

  // Repeat timing runs only while the level stays pressed across the edge,
  // so the release cycle and the press cycle itself never repeat.
  always_comb begin
    for (int i = 0; i < NUM_BOTONES; i++) begin
      w_fase_sig[i]  = REP_RETARDO;
      w_rep_sig[i]   = '0;
      w_rep_pulso[i] = 1'b0;
      if (r_nivel[i] && w_nivel_sig[i]) begin
        unique case (r_fase[i])
          REP_RETARDO: begin
            if (r_rep[i] == LIM_RET) begin
              w_rep_pulso[i] = 1'b1;
              w_fase_sig[i]  = REP_PERIODO;
              w_rep_sig[i]   = '0;
            end else begin
              w_fase_sig[i]  = REP_RETARDO;
              w_rep_sig[i]   = r_rep[i] + RW'(1);
            end
          end
          REP_PERIODO: begin
            w_fase_sig[i] = REP_PERIODO;
            if (r_rep[i] == LIM_PER) begin
              w_rep_pulso[i] = 1'b1;
              w_rep_sig[i]   = '0;
            end else begin
              w_rep_sig[i]   = r_rep[i] + RW'(1);
            end
          end
          default: begin
            w_fase_sig[i] = REP_RETARDO;
            w_rep_sig[i]  = '0;
          end
        endcase
      end
    end
  end

`else

  logic w_unused_rep;

  assign w_unused_rep =
    ^{RETARDO_REPETICION, PERIODO_REPETICION};
  assign w_rep_pulso = '0;

`endif

  assign w_pulsos_sig = w_sube | w_rep_pulso;

  // Level, counters and pulse register; reset dominates any update.
  always_ff @(posedge reloj) begin
    if (reinicio) begin
      r_nivel  <= '0;
      r_pulsos <= '0;
      for (int i = 0; i < NUM_BOTONES; i++) begin
        r_cuenta[i] <= '0;
      end
    end else begin
      r_nivel  <= w_nivel_sig;
      r_pulsos <= w_pulsos_sig;
      for (int i = 0; i < NUM_BOTONES; i++) begin
        r_cuenta[i] <= w_cuenta_sig[i];
      end
    end
  end

  assign salidaNivel  = r_nivel;
  assign salidaPulsos = r_pulsos;

endmodule
